// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of the UART transmitter,
// handing it one byte per frame paced by its active/done flags.
module uart_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             flush,
  input  logic             active_flag,
  input  logic             done_flag,
  output logic             send,
  output logic [7:0]       data_in,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             busy,
  output logic [15:0]      tx_count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       act_sync_q, done_sync_q;
  logic             act_s, done_s;
  logic [7:0]       mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       data_q;
  logic [15:0]      tx_count_q;
  logic             ovf_q, ovf_d;
  logic             push, pop, tx_inc;

  assign act_s  = act_sync_q[1];
  assign done_s = done_sync_q[1];

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign data_in  = data_q;
  assign tx_count = tx_count_q;
  assign send     = (state_q == REQ);
  assign busy     = (state_q != IDLE);

  // flush wins over a same-cycle write and suppresses overflow
  assign push  = wr_en & ~full & ~flush;
  assign ovf_d = wr_en & full & ~flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !act_s) begin
          pop     = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (act_s) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_s && !act_s) begin
          tx_inc  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      act_sync_q  <= '0;
      done_sync_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      data_q      <= 8'h00;
      tx_count_q  <= 16'h0000;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_sync_q  <= {act_sync_q[0], active_flag};
      done_sync_q <= {done_sync_q[0], done_flag};
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      if (pop)    data_q     <= mem_q[rptr_q];
      if (tx_inc) tx_count_q <= tx_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: scoreboard bench with a behavioural
// transmitter answering send with active/done flags.
module tb_uart_tx_feeder;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        flush;
  logic        active_flag;
  logic        done_flag;
  logic        send;
  logic [7:0]  data_in;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
  logic        busy;
  logic [15:0] tx_count;

  logic m_act = 1'b0;
  logic m_done = 1'b0;
  logic t_act = 1'b0;
  bit   tx_en = 1'b1;
  int   act_dly = 3;
  int   done_dly = 8;

  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  logic [15:0] txc_exp;
  int passed = 0;
  int total = 0;

  assign active_flag = m_act | t_act;
  assign done_flag   = m_done;

  uart_tx_feeder #(.DEPTH(16), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en),
    .wr_data(wr_data), .flush(flush),
    .active_flag(active_flag), .done_flag(done_flag),
    .send(send), .data_in(data_in), .full(full),
    .empty(empty), .count(count), .overflow(overflow),
    .busy(busy), .tx_count(tx_count)
  );

  always #5 clock = ~clock;

  // transmitter model: captures the byte, then raises flags
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (tx_en && send && !reset) begin
        obs_q.push_back(data_in);
        repeat (act_dly) @(posedge clock);
        #3 m_act = 1'b1;
        repeat (done_dly - act_dly) @(posedge clock);
        #3 m_act = 1'b0;
        m_done = 1'b1;
        repeat (2) @(posedge clock);
        #3 m_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_wr(input logic [7:0] b, input bit kept);
    wr_en = 1'b1;
    wr_data = b;
    if (kept) exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    txc_exp = 16'h0000;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic wait_txc(input logic [15:0] tgt, input int lim,
                          output bit ok);
    int n;
    n = 0;
    while (tx_count !== tgt && n < lim) begin
      tick();
      n++;
    end
    ok = (tx_count === tgt);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    flush = 1'b0;
    tick();
    tick();
    total++; if (send !== 1'b0) $display("FAIL rst_send got %b want 0", send); else passed++;
    total++; if (data_in !== 8'h00) $display("FAIL rst_data got %h want 00", data_in); else passed++;
    total++; if (full !== 1'b0) $display("FAIL rst_full got %b want 0", full); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL rst_empty got %b want 1", empty); else passed++;
    total++; if (count !== 5'd0) $display("FAIL rst_count got %0d want 0", count); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %b want 0", overflow); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    total++; if (tx_count !== 16'h0) $display("FAIL rst_txc got %h want 0000", tx_count); else passed++;
    reset = 1'b0;
    tick();
    txc_exp = 16'h0000;
  endtask

  task automatic test_single();
    int ca, cs, cyc;
    bit held;
    logic [7:0] e, o;
    act_dly = 40;
    done_dly = 200;
    drive_wr(8'hA5, 1'b1);
    total++; if (empty !== 1'b0) $display("FAIL single_empty got %b want 0", empty); else passed++;
    total++; if (send !== 1'b0) $display("FAIL single_send_n got %b want 0", send); else passed++;
    tick();
    total++; if (send !== 1'b1) $display("FAIL single_send got %b want 1", send); else passed++;
    total++; if (data_in !== 8'hA5) $display("FAIL single_data got %h want a5", data_in); else passed++;
    ca = -1;
    cs = -1;
    cyc = 0;
    held = 1'b1;
    while (busy && cyc < 400) begin
      tick();
      cyc++;
      if (active_flag && ca < 0) ca = cyc;
      if (!send && cs < 0) cs = cyc;
      if (data_in !== 8'hA5) held = 1'b0;
    end
    txc_exp = txc_exp + 16'd1;
    total++; if (cs - ca !== 2) $display("FAIL single_fall got %0d want 2 edges", cs - ca); else passed++;
    total++; if (held !== 1'b1) $display("FAIL single_hold got %b want 1", held); else passed++;
    total++; if (tx_count !== txc_exp) $display("FAIL single_txc got %h want %h", tx_count, txc_exp); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_busy got %b want 0", busy); else passed++;
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL single_sb_n got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL single_sb got %h want %h", o, e); else passed++;
    end
    act_dly = 3;
    done_dly = 8;
  endtask

  task automatic test_burst();
    bit ok;
    logic [7:0] e, o;
    apply_reset();
    t_act = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 17; i++) begin
      drive_wr(8'(i), i < 16);
      if (i == 14) begin
        total++; if (full !== 1'b0) $display("FAIL burst_full15 got %b want 0", full); else passed++;
      end
      if (i == 15) begin
        total++; if (full !== 1'b1) $display("FAIL burst_full got %b want 1", full); else passed++;
        total++; if (count !== 5'd16) $display("FAIL burst_cnt got %0d want 16", count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL burst_ovf0 got %b want 0", overflow); else passed++;
      end
      if (i == 16) begin
        total++; if (overflow !== 1'b1) $display("FAIL burst_ovf got %b want 1", overflow); else passed++;
        total++; if (count !== 5'd16) $display("FAIL burst_cnt17 got %0d want 16", count); else passed++;
      end
    end
    tick();
    total++; if (overflow !== 1'b0) $display("FAIL burst_ovf_end got %b want 0", overflow); else passed++;
    t_act = 1'b0;
    txc_exp = txc_exp + 16'd16;
    wait_txc(txc_exp, 2000, ok);
    total++; if (!ok) $display("FAIL burst_txc got %h want %h", tx_count, txc_exp); else passed++;
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL burst_sb_n got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL burst_sb got %h want %h", o, e); else passed++;
    end
  endtask

  task automatic test_simul();
    bit ok;
    logic [7:0] e, o;
    t_act = 1'b1;
    repeat (3) tick();
    drive_wr(8'h11, 1'b1);
    drive_wr(8'h22, 1'b1);
    drive_wr(8'h33, 1'b1);
    total++; if (count !== 5'd3) $display("FAIL simul_pre got %0d want 3", count); else passed++;
    t_act = 1'b0;
    tick();
    tick();
    total++; if (send !== 1'b0) $display("FAIL simul_send_n got %b want 0", send); else passed++;
    drive_wr(8'h44, 1'b1);
    total++; if (send !== 1'b1) $display("FAIL simul_send got %b want 1", send); else passed++;
    total++; if (count !== 5'd3) $display("FAIL simul_cnt got %0d want 3", count); else passed++;
    txc_exp = txc_exp + 16'd4;
    wait_txc(txc_exp, 1000, ok);
    total++; if (!ok) $display("FAIL simul_txc got %h want %h", tx_count, txc_exp); else passed++;
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL simul_sb_n got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL simul_sb got %h want %h", o, e); else passed++;
    end
  endtask

  task automatic test_flush();
    bit ok;
    int n;
    logic [7:0] e, o;
    t_act = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) drive_wr(8'hC0 + 8'(i), 1'b1);
    t_act = 1'b0;
    n = 0;
    while (!(busy && !send) && n < 200) begin
      tick();
      n++;
    end
    total++; if (!(busy && !send)) $display("FAIL flush_wait got busy=%b send=%b want 1/0", busy, send); else passed++;
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    total++; if (count !== 5'd0) $display("FAIL flush_cnt got %0d want 0", count); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL flush_empty got %b want 1", empty); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL flush_ovf got %b want 0", overflow); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL flush_busy got %b want 1", busy); else passed++;
    txc_exp = txc_exp + 16'd1;
    wait_txc(txc_exp, 500, ok);
    repeat (20) tick();
    total++; if (tx_count !== txc_exp) $display("FAIL flush_txc got %h want %h", tx_count, txc_exp); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL flush_idle got %b want 0", busy); else passed++;
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL flush_sb_n got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL flush_sb got %h want %h", o, e); else passed++;
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [7:0] e, o;
    tx_en = 1'b0;
    drive_wr(8'h01, 1'b0);
    drive_wr(8'h02, 1'b0);
    drive_wr(8'h03, 1'b0);
    total++; if (send !== 1'b1) $display("FAIL arst_req got %b want 1", send); else passed++;
    total++; if (count !== 5'd2) $display("FAIL arst_pre got %0d want 2", count); else passed++;
    @(posedge clock);
    #5 reset = 1'b1;
    #1;
    total++; if (send !== 1'b0) $display("FAIL arst_send got %b want 0", send); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL arst_busy got %b want 0", busy); else passed++;
    total++; if (count !== 5'd0) $display("FAIL arst_cnt got %0d want 0", count); else passed++;
    #2 reset = 1'b0;
    tick();
    exp_q.delete();
    obs_q.delete();
    txc_exp = 16'h0000;
    tx_en = 1'b1;
    drive_wr(8'h3C, 1'b1);
    txc_exp = txc_exp + 16'd1;
    wait_txc(txc_exp, 500, ok);
    total++; if (!ok) $display("FAIL arst_txc got %h want %h", tx_count, txc_exp); else passed++;
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL arst_sb_n got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL arst_sb got %h want %h", o, e); else passed++;
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int n;
    logic [7:0] e, o;
    force dut.tx_count_q = 16'hFFFF;
    #1;
    release dut.tx_count_q;
    tick();
    total++; if (tx_count !== 16'hFFFF) $display("FAIL wrap_pre got %h want ffff", tx_count); else passed++;
    drive_wr(8'h5A, 1'b1);
    txc_exp = 16'h0000;
    wait_txc(txc_exp, 500, ok);
    total++; if (!ok) $display("FAIL wrap_txc got %h want 0000", tx_count); else passed++;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (full && n < 200) begin
        tick();
        n++;
      end
      drive_wr(8'(i * 7 + 3), 1'b1);
    end
    txc_exp = txc_exp + 16'd40;
    wait_txc(txc_exp, 3000, ok);
    total++; if (!ok) $display("FAIL wrap_txc40 got %h want %h", tx_count, txc_exp); else passed++;
    total++; if (obs_q.size() !== exp_q.size()) $display("FAIL wrap_sb_n got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL wrap_sb got %h want %h", o, e); else passed++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_simul();
    test_flush();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
